// File: rtl/kf_dma_priority_arbiter.sv
// DMA channel arbiter: mask/request/command registers, fixed or rotating priority,
// and a one-hot grant handed to the timing FSM over valid/ready, held until EOP.
module kf_dma_priority_arbiter #(
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          internal_data_bus,
    input  logic                write_command_register,
    input  logic                write_request_register,
    input  logic                set_or_reset_mask_register,
    input  logic                write_mask_register,
    input  logic                master_clear,
    input  logic                clear_mask_register,
    input  logic [CHANNELS-1:0] dma_request,
    input  logic [CHANNELS-1:0] dma_acknowledge_internal,
    input  logic                end_of_process,
    input  logic                grant_ready,
    output logic                grant_valid,
    output logic [CHANNELS-1:0] encoded_dma,
    output logic [CH_BITS-1:0]  granted_channel,
    output logic [CHANNELS-1:0] request_status,
    output logic [CHANNELS-1:0] mask_status
);

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, SERVICE = 2'd2} state_t;

    state_t              state, state_nxt;
    logic [CHANNELS-1:0] mask_q, mask_nxt, req_q, req_nxt, req_clr;
    logic [CHANNELS-1:0] dreq_p1, hw_req, eff_req, sel_onehot, grant_onehot;
    logic                cmd_disable, cmd_rotate, cmd_active_low;
    logic [CH_BITS-1:0]  last_serviced, grant_ch, sel_ch, start_ch, winner;
    logic                sel_set, winner_found, grant_load, service_done;
    logic                unused_data;

    function automatic logic is_onehot(input logic [CHANNELS-1:0] v);
        return (v != '0) && ((v & (v - CHANNELS'(1))) == '0);
    endfunction

    assign sel_ch       = internal_data_bus[CH_BITS-1:0];
    assign sel_set      = internal_data_bus[CH_BITS];
    assign sel_onehot   = CHANNELS'(1) << sel_ch;
    assign grant_onehot = CHANNELS'(1) << grant_ch;
    assign unused_data  = ^internal_data_bus;

    // stage p1: sampled DREQ, polarity correction, mask, software requests
    assign hw_req  = dreq_p1 ^ {CHANNELS{cmd_active_low}};
    assign eff_req = (hw_req & ~mask_q) | req_q;

    assign start_ch = !cmd_rotate ? '0 :
                      (last_serviced == CH_BITS'(CHANNELS - 1)) ? '0 :
                      last_serviced + CH_BITS'(1);

    // Scan upward from start_ch, wrapping at CHANNELS (not at 2**CH_BITS).
    always_comb begin : pick
        logic [CH_BITS-1:0] idx;
        winner       = '0;
        winner_found = 1'b0;
        idx          = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = CH_BITS'((int'(start_ch) + k) % CHANNELS);
            if (!winner_found && eff_req[idx]) begin
                winner       = idx;
                winner_found = 1'b1;
            end
        end
    end

    assign grant_load   = (state == IDLE) && (state_nxt == GRANT);
    assign service_done = (state == SERVICE) && end_of_process;

    // A software set is applied after the EOP clear so it wins on the same bit.
    always_comb begin : reg_next
        req_clr = '0;
        if (service_done)
            req_clr = grant_onehot;
        else if (end_of_process && is_onehot(dma_acknowledge_internal))
            req_clr = dma_acknowledge_internal;
        req_nxt = req_q & ~req_clr;
        if (write_request_register)
            req_nxt = sel_set ? (req_nxt | sel_onehot) : (req_nxt & ~sel_onehot);

        mask_nxt = mask_q;
        if (set_or_reset_mask_register)
            mask_nxt = sel_set ? (mask_nxt | sel_onehot) : (mask_nxt & ~sel_onehot);
        if (write_mask_register)
            mask_nxt = internal_data_bus[CHANNELS-1:0];
        if (clear_mask_register)
            mask_nxt = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask_q         <= '1;
            req_q          <= '0;
            cmd_disable    <= 1'b0;
            cmd_rotate     <= 1'b0;
            cmd_active_low <= 1'b0;
            last_serviced  <= CH_BITS'(CHANNELS - 1);
            grant_ch       <= '0;
            dreq_p1        <= '0;
        end else begin
            dreq_p1 <= dma_request;
            if (master_clear) begin
                mask_q         <= '1;
                req_q          <= '0;
                cmd_disable    <= 1'b0;
                cmd_rotate     <= 1'b0;
                cmd_active_low <= 1'b0;
                last_serviced  <= CH_BITS'(CHANNELS - 1);
                grant_ch       <= '0;
            end else begin
                mask_q <= mask_nxt;
                req_q  <= req_nxt;
                if (write_command_register) begin
                    cmd_disable    <= internal_data_bus[2];
                    cmd_rotate     <= internal_data_bus[4];
                    cmd_active_low <= internal_data_bus[6];
                end
                if (grant_load)
                    grant_ch <= winner;
                if (service_done)
                    last_serviced <= grant_ch;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Acceptance takes precedence over withdrawal when both occur on one edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (winner_found && !cmd_disable) state_nxt = GRANT;
            GRANT: begin
                if (grant_ready)
                    state_nxt = SERVICE;
                else if (!eff_req[grant_ch] || cmd_disable)
                    state_nxt = IDLE;
            end
            SERVICE: if (end_of_process) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (master_clear)
            state_nxt = IDLE;
    end

    always_comb begin
        grant_valid     = (state == GRANT);
        encoded_dma     = (state != IDLE) ? grant_onehot : '0;
        granted_channel = (state != IDLE) ? grant_ch : '0;
        request_status  = req_q;
        mask_status     = mask_q;
    end

endmodule

// File: tb/tb_kf_dma_priority_arbiter.sv
// Bench for kf_dma_priority_arbiter: register table, directed scenarios, an
// 8-channel instance, and random traffic against a transaction-level model.
module tb_kf_dma_priority_arbiter;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] internal_data_bus = '0;
    logic       write_command_register = 0, write_request_register = 0;
    logic       set_or_reset_mask_register = 0, write_mask_register = 0;
    logic       master_clear = 0, clear_mask_register = 0;
    logic [3:0] dma_request = '0, dma_acknowledge_internal = '0;
    logic       end_of_process = 0, grant_ready = 0;
    logic       grant_valid;
    logic [3:0] encoded_dma, request_status, mask_status;
    logic [1:0] granted_channel;

    logic       r8 = 1'b1;
    logic [7:0] d8_data = '0, d8_dreq = '0;
    logic       d8_wcmd = 0, d8_wmask = 0, d8_eop = 0, d8_ready = 0;
    logic       d8_valid;
    logic [7:0] d8_enc, d8_req, d8_mask;
    logic [2:0] d8_ch;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    kf_dma_priority_arbiter #(.CHANNELS(4), .CH_BITS(2)) dut (
        .clock(clock), .reset(reset), .internal_data_bus(internal_data_bus),
        .write_command_register(write_command_register),
        .write_request_register(write_request_register),
        .set_or_reset_mask_register(set_or_reset_mask_register),
        .write_mask_register(write_mask_register), .master_clear(master_clear),
        .clear_mask_register(clear_mask_register), .dma_request(dma_request),
        .dma_acknowledge_internal(dma_acknowledge_internal),
        .end_of_process(end_of_process), .grant_ready(grant_ready),
        .grant_valid(grant_valid), .encoded_dma(encoded_dma),
        .granted_channel(granted_channel), .request_status(request_status),
        .mask_status(mask_status)
    );

    kf_dma_priority_arbiter #(.CHANNELS(8), .CH_BITS(3)) dut8 (
        .clock(clock), .reset(r8), .internal_data_bus(d8_data),
        .write_command_register(d8_wcmd), .write_request_register(1'b0),
        .set_or_reset_mask_register(1'b0), .write_mask_register(d8_wmask),
        .master_clear(1'b0), .clear_mask_register(1'b0), .dma_request(d8_dreq),
        .dma_acknowledge_internal(8'h00), .end_of_process(d8_eop),
        .grant_ready(d8_ready), .grant_valid(d8_valid), .encoded_dma(d8_enc),
        .granted_channel(d8_ch), .request_status(d8_req), .mask_status(d8_mask)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_strobes();
        write_command_register = 0; write_request_register = 0;
        set_or_reset_mask_register = 0; write_mask_register = 0;
        master_clear = 0; clear_mask_register = 0;
        end_of_process = 0; grant_ready = 0;
    endtask

    // kind: 0 command, 1 request, 2 single mask, 3 write mask, 4 clear mask,
    //       5 write+clear mask together, 6 master clear
    task automatic reg_write(input int kind, input logic [7:0] data);
        internal_data_bus          = data;
        write_command_register     = (kind == 0);
        write_request_register     = (kind == 1);
        set_or_reset_mask_register = (kind == 2);
        write_mask_register        = (kind == 3) || (kind == 5);
        clear_mask_register        = (kind == 4) || (kind == 5);
        master_clear               = (kind == 6);
        cyc();
        clear_strobes();
    endtask

    task automatic wait_grant(input int ch, input string name);
        int t = 0;
        while (!grant_valid && t < 20) begin
            cyc();
            t++;
        end
        check(name, {grant_valid, encoded_dma, 2'b00, granted_channel},
              {1'b1, 4'(1 << ch), 2'b00, 2'(ch)});
    endtask

    task automatic serve();
        grant_ready = 1; cyc(); grant_ready = 0;
        end_of_process = 1; cyc(); end_of_process = 0;
    endtask

    // Transaction-level model: phase 0 = no grant, 1 = offered, 2 = in service.
    int m_mask, m_req, m_dis, m_rot, m_alow, m_dreq, m_last, m_phase, m_gch;

    task automatic model_reset();
        m_mask = 'hF; m_req = 0; m_dis = 0; m_rot = 0; m_alow = 0;
        m_last = N - 1; m_phase = 0; m_gch = 0;
    endtask

    function automatic int m_eff();
        int hw = m_dreq ^ (m_alow ? 'hF : 0);
        return ((hw & ~m_mask) | m_req) & 'hF;
    endfunction

    function automatic int m_pick(input int eff);
        int first = m_rot ? (m_last + 1) % N : 0;
        for (int k = 0; k < N; k++)
            if (((eff >> ((first + k) % N)) & 1) != 0) return (first + k) % N;
        return 0;
    endfunction

    function automatic int m_expected();
        int v   = (m_phase == 1) ? 1 : 0;
        int enc = (m_phase != 0) ? (1 << m_gch) : 0;
        int ch  = (m_phase != 0) ? m_gch : 0;
        return (v << 14) | (enc << 10) | (ch << 8) | (m_req << 4) | m_mask;
    endfunction

    task automatic model_step();
        int eff = m_eff();
        int d   = int'(internal_data_bus);
        int bit_sel = 1 << (d & 3);
        int set = (d >> 2) & 1;
        int n_phase = m_phase, n_gch = m_gch, n_last = m_last;
        int n_req = m_req, n_mask = m_mask;
        if (master_clear) begin
            model_reset();
        end else begin
            if (m_phase == 0 && eff != 0 && m_dis == 0) begin
                n_phase = 1; n_gch = m_pick(eff);
            end else if (m_phase == 1) begin
                if (grant_ready) n_phase = 2;
                else if (((eff >> m_gch) & 1) == 0 || m_dis != 0) n_phase = 0;
            end else if (m_phase == 2 && end_of_process) begin
                n_phase = 0; n_last = m_gch;
            end
            if (end_of_process) begin
                if (m_phase == 2) n_req = n_req & ~(1 << m_gch);
                else if ($countones(dma_acknowledge_internal) == 1)
                    n_req = n_req & ~int'(dma_acknowledge_internal);
            end
            if (write_request_register)
                n_req = set ? (n_req | bit_sel) : (n_req & ~bit_sel);
            if (set_or_reset_mask_register)
                n_mask = set ? (n_mask | bit_sel) : (n_mask & ~bit_sel);
            if (write_mask_register) n_mask = d & 'hF;
            if (clear_mask_register) n_mask = 0;
            if (write_command_register) begin
                m_dis = (d >> 2) & 1; m_rot = (d >> 4) & 1; m_alow = (d >> 6) & 1;
            end
            m_phase = n_phase; m_gch = n_gch; m_last = n_last;
            m_req = n_req & 'hF; m_mask = n_mask & 'hF;
        end
        m_dreq = int'(dma_request);
    endtask

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic [3:0] exp_mask;
        logic [3:0] exp_req;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] cmd_tab [6] = '{8'h00, 8'h10, 8'h40, 8'h50, 8'h04, 8'h10};
    int         op;
    int         t8;
    int         rot_order[5] = '{0, 1, 2, 3, 0};
    logic       withdraw;

    initial begin
        vecs.push_back('{3, 8'h05, 4'h5, 4'h0});
        vecs.push_back('{2, 8'h05, 4'h7, 4'h0});
        vecs.push_back('{2, 8'h00, 4'h6, 4'h0});
        vecs.push_back('{5, 8'h0F, 4'h0, 4'h0});
        vecs.push_back('{1, 8'h06, 4'h0, 4'h4});
        vecs.push_back('{1, 8'h07, 4'h0, 4'hC});
        vecs.push_back('{1, 8'h02, 4'h0, 4'h8});
        vecs.push_back('{2, 8'h07, 4'h8, 4'h8});
        vecs.push_back('{6, 8'h00, 4'hF, 4'h0});

        // Reset state
        cyc(); cyc();
        check("reset_outputs", {grant_valid, encoded_dma, granted_channel, request_status},
              11'h000);
        check("reset_mask", mask_status, 4'hF);
        reset = 0;
        cyc();

        // Fixed priority, all requesting, latency of two edges
        reg_write(3, 8'h00);
        dma_request = 4'hF;
        cyc();
        check("latency_1edge_valid", grant_valid, 1'b0);
        cyc();
        check("latency_2edge_grant", {grant_valid, encoded_dma, granted_channel}, 7'b1_0001_00);
        grant_ready = 1; cyc(); grant_ready = 0;
        check("service_hold", {grant_valid, encoded_dma}, 5'b0_0001);
        end_of_process = 1; cyc(); end_of_process = 0;
        check("eop_release", {grant_valid, encoded_dma}, 5'b0_0000);
        cyc();
        check("fixed_regrant_ch0", {grant_valid, encoded_dma}, 5'b1_0001);

        // Mask steering in fixed mode
        reg_write(6, 8'h00);
        reg_write(3, 8'h01);
        wait_grant(1, "mask0001_ch1");
        grant_ready = 1; cyc(); grant_ready = 0;
        reg_write(3, 8'h03);
        end_of_process = 1; cyc(); end_of_process = 0;
        wait_grant(2, "mask0011_ch2");

        // Rotating priority: 0,1,2,3 then wrap to 0
        reg_write(6, 8'h00);
        reg_write(3, 8'h00);
        reg_write(0, 8'h10);
        for (int i = 0; i < 5; i++) begin
            wait_grant(rot_order[i], $sformatf("rotate_step%0d", i));
            serve();
        end

        // Active-low DREQ, then disable withdraws the grant
        dma_request = 4'b0111;
        reg_write(6, 8'h00);
        reg_write(0, 8'h40);
        reg_write(3, 8'h00);
        wait_grant(3, "active_low_ch3");
        reg_write(0, 8'h44);
        cyc();
        check("disable_withdraw", {grant_valid, encoded_dma}, 5'b0_0000);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("disabled_no_grant", grant_valid, 1'b0);
        end

        // Software request ignores mask, cleared by EOP, set beats EOP clear
        dma_request = 4'h0;
        reg_write(6, 8'h00);
        reg_write(1, 8'h06);
        check("sw_req_set", request_status, 4'h4);
        wait_grant(2, "sw_req_grant");
        serve();
        check("sw_req_eop_clear", request_status, 4'h0);
        reg_write(1, 8'h06);
        wait_grant(2, "sw_req_grant2");
        grant_ready = 1; cyc(); grant_ready = 0;
        end_of_process = 1;
        reg_write(1, 8'h06);
        check("sw_set_beats_eop", {request_status, encoded_dma}, 8'h40);

        // Register write table
        reg_write(6, 8'h00);
        foreach (vecs[i]) begin
            reg_write(vecs[i].kind, vecs[i].data);
            check($sformatf("table%0d_mask", i), mask_status, vecs[i].exp_mask);
            check($sformatf("table%0d_req", i), request_status, vecs[i].exp_req);
        end

        // Eight channels, rotating with wrap 7 -> 0, async reset mid-service
        r8 = 0;
        cyc();
        d8_wmask = 1; d8_data = 8'h00; cyc(); d8_wmask = 0;
        d8_wcmd = 1; d8_data = 8'h10; cyc(); d8_wcmd = 0;
        d8_dreq = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            t8 = 0;
            while (!d8_valid && t8 < 20) begin
                cyc();
                t8++;
            end
            check($sformatf("ch8_rotate_step%0d", i), {d8_valid, d8_enc},
                  {1'b1, 8'(1 << (i % 8))});
            d8_ready = 1; cyc(); d8_ready = 0;
            if (i < 8) begin
                d8_eop = 1; cyc(); d8_eop = 0;
            end
        end
        check("ch8_in_service", {d8_valid, d8_enc}, 9'h001);
        #2 r8 = 1;
        #1;
        check("ch8_async_reset", {d8_valid, d8_enc, d8_ch, d8_req}, 20'h0);
        check("ch8_async_reset_mask", d8_mask, 8'hFF);

        // Random traffic against the model
        clear_strobes();
        reset = 1;
        cyc();
        reset = 0;
        model_reset();
        m_dreq = 0;
        for (int c = 0; c < 3000; c++) begin
            check("random_cycle",
                  {17'b0, grant_valid, encoded_dma, granted_channel, request_status, mask_status},
                  32'(m_expected()));
            op = $urandom_range(0, 15);
            internal_data_bus = 8'($urandom_range(0, 255));
            if (op == 0) internal_data_bus = cmd_tab[$urandom_range(0, 5)];
            write_command_register     = (op == 0);
            write_request_register     = (op == 1);
            set_or_reset_mask_register = (op == 2);
            write_mask_register        = (op == 3) || (op == 5);
            clear_mask_register        = (op == 4) || (op == 5);
            master_clear               = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) dma_request = 4'($urandom_range(0, 15));
            end_of_process = ($urandom_range(0, 3) == 0);
            dma_acknowledge_internal = ($urandom_range(0, 1) == 1) ?
                4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            withdraw = (m_phase == 1) && ((((m_eff() >> m_gch) & 1) == 0) || m_dis != 0);
            grant_ready = ($urandom_range(0, 1) == 1) && !withdraw;
            model_step();
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kf_dma_priority_arbiter.md
Name: kf_dma_priority_arbiter

Overview:
- Parametrised successor to the 4-channel DMA priority encoder.
- Holds the mask, software-request and priority-control registers.
- Arbitrates CHANNELS DREQ lines with fixed or rotating priority and issues one-hot grants to the timing FSM over a valid/ready handshake.
- Holds each grant through service until end_of_process and records the serviced channel for rotation.

Parameters:
CHANNELS, 4, number of DMA channels (2..8)
CH_BITS, 2, channel index width; must equal clog2(CHANNELS) (1..3)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous active-high reset
internal_data_bus  input  8  CPU write data
write_command_register  input  1  strobe: command write
write_request_register  input  1  strobe: software request set/clear
set_or_reset_mask_register  input  1  strobe: single mask bit set/clear
write_mask_register  input  1  strobe: write all mask bits
master_clear  input  1  synchronous soft reset
clear_mask_register  input  1  strobe: clear all mask bits
dma_request  input  CHANNELS  raw DREQ lines
dma_acknowledge_internal  input  CHANNELS  one-hot DACK from the timing FSM
end_of_process  input  1  terminal count / EOP pulse
grant_ready  input  1  timing FSM accepts grant
grant_valid  output  1  grant offered
encoded_dma  output  CHANNELS  one-hot granted channel
granted_channel  output  CH_BITS  binary index of the granted channel
request_status  output  CHANNELS  software request register
mask_status  output  CHANNELS  mask register

Behaviour:
- Reset and master_clear:
  - mask = all ones; request register = 0; command = 0.
  - last_serviced = CHANNELS-1; FSM = IDLE.
  - All outputs are 0, except mask_status, which is all ones.
  - master_clear takes effect at the next edge and aborts any grant.
- Register writes (visible at the next edge):
  - Command register: bit2 = controller disable; bit4 = rotating priority; bit6 = DREQ active-low. Other bits are ignored.
  - Request register: channel select = data[CH_BITS-1:0]; data[CH_BITS] = 1 sets the bit, 0 clears it.
  - Single mask bit: same channel-select/set encoding as the request register.
  - write_mask_register: mask = data[CHANNELS-1:0].
  - clear_mask_register: mask = 0.
- DREQ path:
  - dma_request is registered once.
  - hw_req = sampled XOR {CHANNELS{bit6}}.
  - eff_req = (hw_req & ~mask) | request_register. Software requests ignore the mask.
- Priority:
  - Fixed: index 0 highest, ascending.
  - Rotating: (last_serviced+1) mod CHANNELS is highest, then wraps upward.
  - last_serviced updates on every service completion in both modes. Switching back to fixed takes effect at the next arbitration.
- FSM IDLE:
  - Go to GRANT when eff_req != 0 and disable = 0.
  - Latch the winner into encoded_dma/granted_channel; grant_valid = 1 in the same edge.
  - Latency: DREQ change at edge t, sampled at t+1, grant_valid high after t+2.
- FSM GRANT:
  - Outputs are held stable.
  - grant_ready = 1 at an edge: go to SERVICE; grant_valid goes to 0.
  - Granted eff_req bit drops, or disable is set, before acceptance: withdraw to IDLE with grant_valid = 0 and encoded_dma = 0.
- FSM SERVICE:
  - encoded_dma is held; disable does not abort.
  - end_of_process = 1: go to IDLE; last_serviced = granted_channel; clear the request register bit of granted_channel; encoded_dma = 0.
  - The next grant is possible no earlier than one IDLE cycle later.
- end_of_process outside SERVICE, with dma_acknowledge_internal one-hot: clear the request bit of the acknowledged channel. Otherwise end_of_process is ignored.
- Simultaneous software set and EOP clear on the same bit: the set wins.
- Simultaneous write_mask_register and clear_mask_register: the clear wins.
- Mask changes during GRANT/SERVICE do not affect the current grant, except that a GRANT is withdrawn if its eff_req bit drops.

Test Plan:
- Reset, then write mask 0x0 and set dma_request = 4'b1111 -> grant ch0 (encoded_dma = 0001, grant_valid high 2 cycles after DREQ). Handshake plus EOP then grants ch0 again in fixed mode.
- Fixed mode, mask = 4'b0001, DREQ = 1111 -> ch1 granted; set mask = 4'b0011 before the next arbitration -> ch2.
- Rotating mode (command 0x10), DREQ = 1111, service each grant with ready plus EOP -> grant order 0,1,2,3,0; last_serviced wraps 3 -> 0.
- Active-low (command 0x40), dma_request = 4'b0111 -> ch3 only requesting, encoded_dma = 1000. Set disable (0x04) while in GRANT -> withdraws to IDLE, no further grants.
- Software request data = 0x06 (ch2 set) with mask all ones -> ch2 granted. EOP in SERVICE -> request_status bit2 cleared. Data 0x06 written in the same cycle as EOP -> bit stays set.
- CHANNELS = 8, CH_BITS = 3: rotating mode, DREQ = 8'hFF -> wrap 7 -> 0. Assert reset mid-SERVICE -> all outputs 0, mask_status = 8'hFF immediately (asynchronous).
